// File: rtl/shared_bus_arbiter_pkg.sv
// Shared definitions for the shared-memory bus arbiter: default widths,
// FSM state encoding and small index helpers.
package shared_bus_arbiter_pkg;

    localparam int unsigned DEF_NUM_CORES  = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_e;

    // Accesses whose top two address bits are non-zero target the shared region.
    function automatic logic shared_region_sel(input logic [15:0] addr);
        return addr[15:14] != 2'b00;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req scanning
// start, start+1, ... modulo NUM_CORES.
module rr_priority_picker #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]         req,
    input  logic [$clog2(NUM_CORES)-1:0] start,
    output logic                         found,
    output logic [$clog2(NUM_CORES)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    always_comb begin
        int unsigned pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            pos = (32'(start) + k) % NUM_CORES;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter of NUM_CORES core requests onto one shared memory port,
// one access in flight, registered grant, combinational read-data return.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES  = DEF_NUM_CORES,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             core_request,
    input  logic [NUM_CORES-1:0]             core_wren,
    input  logic [NUM_CORES-1:0]             core_rden,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_val,
    output logic [NUM_CORES-1:0]             core_ready,
    output logic [DATA_WIDTH-1:0]            core_read_val,
    output logic                             mem_request,
    output logic                             mem_wren,
    output logic                             mem_rden,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_write_val,
    input  logic                             mem_ready,
    input  logic [DATA_WIDTH-1:0]            mem_read_val
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_CORES-1:0] pick_req;
    logic [IDX_W-1:0]     pick_start;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 g_req;
    logic [IDX_W-1:0]     grant_next;

    // Single picker serves both the idle pick and the back-to-back pick.
    rr_priority_picker #(.NUM_CORES(NUM_CORES)) u_picker (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign core_read_val = mem_read_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        g_req         = core_request[grant_idx_q];
        grant_next    = IDX_W'(wrap_inc(32'(grant_idx_q), NUM_CORES));
        pick_req      = core_request;
        pick_start    = rr_ptr_q;
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        core_ready    = '0;
        mem_request   = 1'b0;
        mem_wren      = 1'b0;
        mem_rden      = 1'b0;
        mem_addr      = '0;
        mem_write_val = '0;

        if (state_q == ST_GRANTED) begin
            pick_req   = core_request & ~(NUM_CORES'(1) << grant_idx_q);
            pick_start = grant_next;

            mem_request   = g_req;
            mem_wren      = core_wren[grant_idx_q] & g_req;
            mem_rden      = core_rden[grant_idx_q] & g_req;
            mem_addr      = core_addr[32'(grant_idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_write_val = core_write_val[32'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
            core_ready[grant_idx_q] = mem_ready & g_req;

            if (!g_req) begin
                state_d = ST_IDLE;
            end else if (mem_ready) begin
                rr_ptr_d = grant_next;
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else if (pick_found) begin
            state_d     = ST_GRANTED;
            grant_idx_d = pick_idx;
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed, table-driven check of shared_bus_arbiter with 4 cores.
module tb_shared_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    core_request;
    logic [N-1:0]    core_wren;
    logic [N-1:0]    core_rden;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_write_val;
    logic [N-1:0]    core_ready;
    logic [DW-1:0]   core_read_val;
    logic            mem_request;
    logic            mem_wren;
    logic            mem_rden;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_val;
    logic            mem_ready;
    logic [DW-1:0]   mem_read_val;

    shared_bus_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_request   (core_request),
        .core_wren      (core_wren),
        .core_rden      (core_rden),
        .core_addr      (core_addr),
        .core_write_val (core_write_val),
        .core_ready     (core_ready),
        .core_read_val  (core_read_val),
        .mem_request    (mem_request),
        .mem_wren       (mem_wren),
        .mem_rden       (mem_rden),
        .mem_addr       (mem_addr),
        .mem_write_val  (mem_write_val),
        .mem_ready      (mem_ready),
        .mem_read_val   (mem_read_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic        mr;
        logic [15:0] mrv;
        logic [3:0]  e_ready;
        logic        e_mreq;
        logic        e_mwr;
        logic        e_mrd;
        logic [15:0] e_addr;
        logic [15:0] e_wval;
    } vec_t;

    vec_t        vecs[17];
    logic [15:0] a_c[4];
    logic [15:0] w_c[4];
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [3:0] e_ready, input logic e_mreq,
                         input logic e_mwr, input logic e_mrd, input logic [15:0] e_addr,
                         input logic [15:0] e_wval, input logic [15:0] e_rdata);
        logic [54:0] got, exp;
        got = {core_ready, mem_request, mem_wren, mem_rden, mem_addr, mem_write_val, core_read_val};
        exp = {e_ready, e_mreq, e_mwr, e_mrd, e_addr, e_wval, e_rdata};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b req=%b wr=%b rd=%b addr=%h wval=%h rdata=%h, expected rdy=%b req=%b wr=%b rd=%b addr=%h wval=%h rdata=%h",
                     name, core_ready, mem_request, mem_wren, mem_rden, mem_addr, mem_write_val, core_read_val,
                     e_ready, e_mreq, e_mwr, e_mrd, e_addr, e_wval, e_rdata);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] wr, input logic [3:0] rd,
                         input logic mr, input logic [15:0] mrv);
        core_request = req;
        core_wren    = wr;
        core_rden    = rd;
        mem_ready    = mr;
        mem_read_val = mrv;
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] wr, input logic [3:0] rd,
                                input logic mr, input logic [15:0] mrv, input logic [3:0] e_ready,
                                input logic e_mreq, input logic e_mwr, input logic e_mrd,
                                input logic [15:0] e_addr, input logic [15:0] e_wval);
        vec_t v;
        v.req = req; v.wr = wr; v.rd = rd; v.mr = mr; v.mrv = mrv;
        v.e_ready = e_ready; v.e_mreq = e_mreq; v.e_mwr = e_mwr; v.e_mrd = e_mrd;
        v.e_addr = e_addr; v.e_wval = e_wval;
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        a_c[0] = 16'h0100; a_c[1] = 16'h8002; a_c[2] = 16'h4010; a_c[3] = 16'hC030;
        w_c[0] = 16'h1111; w_c[1] = 16'h1234; w_c[2] = 16'h2222; w_c[3] = 16'h3333;
        core_addr      = {a_c[3], a_c[2], a_c[1], a_c[0]};
        core_write_val = {w_c[3], w_c[2], w_c[1], w_c[0]};

        // One cycle per row, starting from reset (IDLE, rr_ptr=0).
        vecs[0]  = mk(4'b0100, 4'b0000, 4'b0100, 1, 16'h0000, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(4'b0100, 4'b0000, 4'b0100, 1, 16'h0000, 4'b0100, 1, 0, 1, 16'h4010, 16'h2222);
        vecs[2]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 16'hBEEF, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[3]  = mk(4'b0010, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[4]  = mk(4'b0010, 4'b0110, 4'b0000, 0, 16'h0000, 4'b0000, 1, 1, 0, 16'h8002, 16'h1234);
        vecs[5]  = mk(4'b0010, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0000, 1, 1, 0, 16'h8002, 16'h1234);
        vecs[6]  = mk(4'b0010, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0000, 1, 1, 0, 16'h8002, 16'h1234);
        vecs[7]  = mk(4'b0010, 4'b0010, 4'b0000, 1, 16'h0000, 4'b0010, 1, 1, 0, 16'h8002, 16'h1234);
        vecs[8]  = mk(4'b1000, 4'b0000, 4'b1000, 0, 16'h0000, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[9]  = mk(4'b1000, 4'b0000, 4'b1000, 0, 16'h0000, 4'b0000, 1, 0, 1, 16'hC030, 16'h3333);
        vecs[10] = mk(4'b0001, 4'b0001, 4'b0001, 1, 16'h0000, 4'b0000, 0, 0, 0, 16'hC030, 16'h3333);
        vecs[11] = mk(4'b0001, 4'b0001, 4'b0001, 1, 16'h0000, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[12] = mk(4'b0001, 4'b0001, 4'b0001, 1, 16'h0000, 4'b0001, 1, 1, 1, 16'h0100, 16'h1111);
        vecs[13] = mk(4'b1001, 4'b0000, 4'b1001, 1, 16'h0000, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[14] = mk(4'b1001, 4'b0000, 4'b1001, 1, 16'h0000, 4'b1000, 1, 0, 1, 16'hC030, 16'h3333);
        vecs[15] = mk(4'b0001, 4'b0000, 4'b0001, 1, 16'h5A5A, 4'b0001, 1, 0, 1, 16'h0100, 16'h1111);
        vecs[16] = mk(4'b0000, 4'b0000, 4'b0000, 1, 16'hC3C3, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000);

        // Reset asserted in the middle of a stalled access.
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 0, 16'h0000);
        repeat (2) @(negedge clk);
        #1 check("in_reset", 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        drive(4'b0100, 4'b0000, 4'b0100, 1, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        drive(4'b0010, 4'b0010, 4'b0000, 0, 16'h0000);
        @(negedge clk);
        #1 check("pre_reset_grant", 4'b0000, 1, 1, 0, 16'h8002, 16'h1234, 16'h0000);
        #2 reset = 1'b0;
        #1 check("async_reset", 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 4'b0000, 1, 16'h0000);
        reset = 1'b1;
        #1 check("post_reset_idle", 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

        // All cores request: first grant must be core 0, then strict rotation.
        @(negedge clk);
        drive(4'b1111, 4'b1111, 4'b0000, 1, 16'h0000);
        #1 check("all_req_idle", 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << (k % 4);
            @(negedge clk);
            #1 check($sformatf("rotate%0d", k), onehot, 1, 1, 0, a_c[k % 4], w_c[k % 4], 16'h0000);
        end

        // Fresh reset, then the table.
        @(negedge clk);
        drive(4'b0000, 4'b0000, 4'b0000, 1, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].wr, vecs[i].rd, vecs[i].mr, vecs[i].mrv);
            #1 check($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_mreq, vecs[i].e_mwr,
                     vecs[i].e_mrd, vecs[i].e_addr, vecs[i].e_wval, vecs[i].mrv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
